// File: rtl/fp8_to_fp12_stream_expander_if.sv
// Stream bundle for the FP8->FP12 expander: packed FP8 words in, FP12 beats out.
// The master modport drives words and accepts beats; the slave modport is the expander.
interface fp8_to_fp12_stream_expander_if #(
   parameter int LANES = 4
);
   localparam int NL_W = $clog2(LANES) + 1;

   logic [8*LANES-1:0] in_data;
   logic [NL_W-1:0]    in_nlanes;
   logic               in_valid;
   logic               in_ready;
   logic [11:0]        out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic               out_special;

   modport master (
      output in_data, in_nlanes, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_special
   );

   modport slave (
      input  in_data, in_nlanes, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, out_special
   );
endinterface

// File: rtl/fp8_to_fp12_stream_expander.sv
// Widens packed FP8 (1/4/3) words into one FP12 (1/4/7) beat per lane, lane 0 first,
// with zero-bubble word chaining and a saturating count of emitted Inf/NaN beats.
module fp8_to_fp12_stream_expander #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   fp8_to_fp12_stream_expander_if.slave  bus,
   input  logic                          cnt_clr,
   output logic [CNT_W-1:0]              special_cnt
);
   localparam int NL_W = $clog2(LANES) + 1;

   typedef enum logic {IDLE, SEND} state_e;

   state_e             state_q;
   logic [8*LANES-1:0] word_q;
   logic [NL_W-1:0]    n_q;
   logic [NL_W-1:0]    n_d;
   logic [NL_W-1:0]    idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [7:0]         lane;
   logic               special;
   logic               last;
   logic               fire;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      lane = 8'h00;
      for (int k = 0; k < LANES; k++) begin
         if (idx_q == NL_W'(k)) lane = word_q[8*k +: 8];
      end
   end

   // Exponent 15 covers both Inf and NaN; all of them leave as canonical Inf.
   assign special = &lane[6:3];
   assign last    = (idx_q == n_q - NL_W'(1));
   assign fire    = bus.out_valid & bus.out_ready;

   assign bus.out_data    = special ? {lane[7], 4'hF, 7'd0} : {lane, 4'b0000};
   assign bus.out_special = special;
   assign bus.out_last    = last;
   assign bus.out_valid   = (state_q == SEND);
   assign bus.in_ready    = (state_q == IDLE) | ((state_q == SEND) & bus.out_ready & last);

   always_comb begin
      n_d = bus.in_nlanes;
      if (bus.in_nlanes == '0 || bus.in_nlanes > NL_W'(LANES)) n_d = NL_W'(LANES);
   end

   // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         n_q     <= NL_W'(LANES);
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  word_q  <= bus.in_data;
                  n_q     <= n_d;
                  idx_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (fire) begin
                  if (!last) begin
                     idx_q <= idx_q + NL_W'(1);
                  end else if (bus.in_valid) begin
                     word_q <= bus.in_data;
                     n_q    <= n_d;
                     idx_q  <= '0;
                  end else begin
                     idx_q   <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                                cnt_d = '0;
      else if (fire && special && cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign special_cnt = cnt_q;
endmodule

// File: tb/tb_fp8_to_fp12_stream_expander.sv
// Directed bench for the FP8->FP12 stream expander; a second instance with a 3-bit
// counter exercises saturation and clear priority in a handful of words.
module tb_fp8_to_fp12_stream_expander;
   logic        clk;
   logic        rst;
   logic        cnt_clr;
   logic        cnt_clr2;
   logic [15:0] special_cnt;
   logic [2:0]  special_cnt2;
   int          tests_run;
   int          tests_failed;
   int          exp_cnt;

   fp8_to_fp12_stream_expander_if #(.LANES(4)) bus ();
   fp8_to_fp12_stream_expander_if #(.LANES(4)) bus2 ();

   fp8_to_fp12_stream_expander #(.LANES(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .special_cnt(special_cnt)
   );

   fp8_to_fp12_stream_expander #(.LANES(4), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .bus(bus2), .cnt_clr(cnt_clr2), .special_cnt(special_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] conv(input logic [7:0] x);
      if (x[6:3] == 4'hF) return {x[7], 4'hF, 7'd0};
      return {x, 4'h0};
   endfunction

   // Presents one word on the main DUT; returns at the negedge where its first beat shows.
   task automatic accept(input logic [31:0] d, input logic [2:0] nl);
      @(negedge clk);
      bus.in_data   = d;
      bus.in_nlanes = nl;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic accept2(input logic [31:0] d);
      @(negedge clk);
      bus2.in_data   = d;
      bus2.in_nlanes = 3'd4;
      bus2.in_valid  = 1'b1;
      bus2.out_ready = 1'b1;
      @(negedge clk);
      bus2.in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] got;
      @(negedge clk);
      got = {bus.out_valid, bus2.out_valid, special_cnt};
      tests_run++;
      if (got !== 18'h0) begin
         tests_failed++;
         $display("FAIL reset_during: got %h expected %h", got, 18'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      got = {bus.out_valid, bus.in_ready, special_cnt};
      tests_run++;
      if (got !== {2'b01, 16'h0}) begin
         tests_failed++;
         $display("FAIL reset_after: got %h expected %h", got, {2'b01, 16'h0});
      end
   endtask

   task automatic test_basic();
      logic [11:0] exp_d [4];
      logic [3:0]  exp_s;
      logic [15:0] got, exp;
      exp_d = '{12'h380, 12'hBD0, 12'h780, 12'h010};
      exp_s = 4'b0100;
      accept(32'h017FBD38, 3'd4);
      for (int i = 0; i < 4; i++) begin
         got = {bus.out_valid, bus.out_last, bus.out_special, bus.in_ready, bus.out_data};
         exp = {1'b1, (i == 3), exp_s[i], (i == 3), exp_d[i]};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL basic_beat%0d: got %h expected %h", i, got, exp);
         end
         @(negedge clk);
      end
      exp_cnt = 1;
      got = {bus.out_valid, bus.in_ready, 14'h0};
      tests_run++;
      if (got !== 16'h4000 || special_cnt !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL basic_end: got valid/ready %h cnt %h expected %h cnt %h",
                  got, special_cnt, 16'h4000, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wa, wb;
      logic [7:0]  x;
      logic [14:0] got, exp;
      wa = 32'h40302010;
      wb = 32'h08182848;
      accept(wa, 3'd4);
      bus.in_data  = wb;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) bus.in_valid = 1'b0;
         x   = (i < 4) ? wa[8*i +: 8] : wb[8*(i-4) +: 8];
         got = {bus.out_valid, bus.out_last, bus.in_ready, bus.out_data};
         exp = {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), conv(x)};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b_beat%0d: got %h expected %h", i, got, exp);
         end
         @(negedge clk);
      end
      tests_run++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL b2b_idle: got %b expected %b", {bus.out_valid, bus.in_ready}, 2'b01);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      logic [14:0] got, exp;
      w = 32'h705A193C;
      accept(w, 3'd4);
      tests_run++;
      if (bus.out_data !== 12'h3C0) begin
         tests_failed++;
         $display("FAIL bp_lane0: got %h expected %h", bus.out_data, 12'h3C0);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         got = {bus.out_valid, bus.out_last, bus.in_ready, bus.out_data};
         exp = {3'b100, 12'h190};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: got %h expected %h", j, got, exp);
         end
         if (j == 3) bus.out_ready = 1'b1;
         @(negedge clk);
      end
      for (int i = 2; i < 4; i++) begin
         got = {bus.out_valid, bus.out_last, bus.in_ready, bus.out_data};
         exp = {1'b1, (i == 3), (i == 3), conv(w[8*i +: 8])};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL bp_after_lane%0d: got %h expected %h", i, got, exp);
         end
         @(negedge clk);
      end
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_idle: got %b expected %b", bus.out_valid, 1'b0);
      end
   endtask

   task automatic test_nlanes();
      logic [31:0] w;
      logic [2:0]  nl_tab [4];
      int          nb_tab [4];
      int          inc_tab [4];
      logic [13:0] got, exp;
      w       = 32'hF82A9105;
      nl_tab  = '{3'd2, 3'd0, 3'd7, 3'd1};
      nb_tab  = '{2, 4, 4, 1};
      inc_tab = '{0, 1, 1, 0};
      for (int t = 0; t < 4; t++) begin
         accept(w, nl_tab[t]);
         for (int i = 0; i < nb_tab[t]; i++) begin
            got = {bus.out_valid, bus.out_last, bus.out_data};
            exp = {1'b1, (i == nb_tab[t] - 1), conv(w[8*i +: 8])};
            tests_run++;
            if (got !== exp) begin
               tests_failed++;
               $display("FAIL nlanes%0d_beat%0d: got %h expected %h", nl_tab[t], i, got, exp);
            end
            @(negedge clk);
         end
         exp_cnt += inc_tab[t];
         tests_run++;
         if (bus.out_valid !== 1'b0 || special_cnt !== 16'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL nlanes%0d_end: got valid %b cnt %h expected valid 0 cnt %h",
                     nl_tab[t], bus.out_valid, special_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      logic [13:0] got, exp;
      accept(32'hF82A9105, 3'd4);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.out_data !== 12'h2A0 || special_cnt !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL rstmid_pre: got %h cnt %h expected %h cnt %h",
                  bus.out_data, special_cnt, 12'h2A0, exp_cnt);
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || special_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL rstmid_same_cycle: got valid %b cnt %h expected valid 0 cnt 0000",
                  bus.out_valid, special_cnt);
      end
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = 0;
      w = 32'h11223344;
      accept(w, 3'd4);
      for (int i = 0; i < 4; i++) begin
         got = {bus.out_valid, bus.out_last, bus.out_data};
         exp = {1'b1, (i == 3), conv(w[8*i +: 8])};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL rstmid_restart_beat%0d: got %h expected %h", i, got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] w;
      logic [2:0]  exp_sat [2];
      w = 32'hFF7FF878;
      exp_sat = '{3'd4, 3'd7};
      for (int k = 0; k < 2; k++) begin
         accept2(w);
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({bus2.out_special, bus2.out_data} !== {1'b1, conv(w[8*i +: 8])}) begin
               tests_failed++;
               $display("FAIL sat_word%0d_beat%0d: got %h expected %h", k, i,
                        {bus2.out_special, bus2.out_data}, {1'b1, conv(w[8*i +: 8])});
            end
            @(negedge clk);
         end
         tests_run++;
         if (special_cnt2 !== exp_sat[k]) begin
            tests_failed++;
            $display("FAIL sat_cnt_word%0d: got %h expected %h", k, special_cnt2, exp_sat[k]);
         end
      end
      accept2(w);
      cnt_clr2 = 1'b1;
      @(negedge clk);
      cnt_clr2 = 1'b0;
      tests_run++;
      if (special_cnt2 !== 3'd0) begin
         tests_failed++;
         $display("FAIL sat_clr_priority: got %h expected %h", special_cnt2, 3'd0);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (special_cnt2 !== 3'd3 || bus2.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_after_clr: got cnt %h valid %b expected cnt %h valid 0",
                  special_cnt2, bus2.out_valid, 3'd3);
      end
      accept(32'h000000F8, 3'd1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      tests_run++;
      if (special_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL main_clr: got %h expected %h", special_cnt, 16'h0);
      end
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      exp_cnt        = 0;
      rst            = 1'b1;
      cnt_clr        = 1'b0;
      cnt_clr2       = 1'b0;
      bus.in_data    = '0;
      bus.in_nlanes  = '0;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus2.in_data   = '0;
      bus2.in_nlanes = '0;
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_nlanes();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
